// File: rtl/bit_index_enum.sv
// bit_index_enum: streams the index of every set bit of an accepted word, lowest first, with a per-word ordinal, a last flag and a single marker beat for all-zero words.
module bit_index_enum #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic [CNT_W-1:0]  out_seq,
   output logic              out_last,
   output logic              out_zero
);
   localparam logic IDLE = 1'b0;
   localparam logic EMIT = 1'b1;

   logic              state;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] rest;
   logic [IDX_W-1:0]  lsb;
   logic              in_fire;
   logic              out_fire;

   // rest is the mask with its lowest set bit cleared; zero means this beat is the last
   assign rest = mask & (mask - DATA_W'(1));

   always_comb begin
      lsb = '0;
      for (int i = DATA_W - 1; i >= 0; i--)
         if (mask[i]) lsb = IDX_W'(i);
   end

   assign out_valid = state == EMIT;
   assign out_index = lsb;
   assign out_last  = out_valid & ~|rest;
   assign out_zero  = out_valid & ~|mask;
   assign in_ready  = (state == IDLE) | (out_ready & out_last);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         mask    <= '0;
         out_seq <= '0;
      end else if (out_fire && !out_last) begin
         mask    <= rest;
         out_seq <= out_seq + CNT_W'(1);
      end else if (in_fire) begin
         state   <= EMIT;
         mask    <= in_data;
         out_seq <= '0;
      end else if (out_fire) begin
         state   <= IDLE;
         mask    <= '0;
         out_seq <= '0;
      end
   end
endmodule
